// File: rtl/cuca_pkg.sv
// Shared definitions for the RAM arbiter: bus width, sequencer states and
// the RAM rw encoding.
package cuca_pkg;
    localparam int BITW = 8;

    localparam logic RAM_READ  = 1'b0;
    localparam logic RAM_WRITE = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        RDATA,
        RCAP
    } arb_state_t;
endpackage

// File: rtl/ram_arbiter_if.sv
// Requester handshake plus RAM/bus signals between the requesters and the
// arbiter. The arbiter takes the slave side.
interface ram_arbiter_if
    import cuca_pkg::*;
#(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_rw;
    logic [NREQ*BITW-1:0] req_addr;
    logic [NREQ*BITW-1:0] req_wdata;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      resp_valid;
    logic [BITW-1:0]      resp_rdata;
    logic                 ram_enable;
    logic                 ram_rw;
    logic [BITW-1:0]      bus_out;
    logic                 bus_oe;
    logic [BITW-1:0]      bus_in;

    modport slave (
        input  req_valid, req_rw, req_addr, req_wdata, bus_in,
        output req_ready, resp_valid, resp_rdata, ram_enable, ram_rw, bus_out, bus_oe
    );

    modport master (
        output req_valid, req_rw, req_addr, req_wdata, bus_in,
        input  req_ready, resp_valid, resp_rdata, ram_enable, ram_rw, bus_out, bus_oe
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the search starts one past the previous
// grant and wraps modulo NREQ.
module rr_arbiter #(
    parameter  int NREQ = 2,
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   gnt_idx
);
    logic found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        // Distance k=1 is the highest priority, k=NREQ (the previous winner) the lowest.
        for (int k = 1; k <= NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && req[i] && ((int'(ptr) + k) % NREQ) == i) begin
                    found   = 1'b1;
                    gnt[i]  = 1'b1;
                    gnt_idx = IW'(i);
                end
            end
        end
    end
endmodule

// File: rtl/ram_arbiter.sv
// Shares the single-port bus RAM among NREQ requesters: round-robin accept,
// then address phase, data phase (plus a capture cycle for reads).
module ram_arbiter
    import cuca_pkg::*;
#(
    parameter  int NREQ = 2,
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input logic          clock,
    input logic          reset,
    ram_arbiter_if.slave bus
);
    arb_state_t      state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            rw_q, rw_d;
    logic [BITW-1:0] addr_q, addr_d;
    logic [BITW-1:0] wdata_q, wdata_d;
    logic [BITW-1:0] rdata_q, rdata_d;
    logic [IW-1:0]   last_q, last_d;
    logic [NREQ-1:0] resp_valid_q, resp_valid_d;

    logic [NREQ-1:0] arb_gnt, ready;
    logic [IW-1:0]   arb_idx;
    logic            sel_rw;
    logic [BITW-1:0] sel_addr, sel_wdata;
    logic            ram_en, ram_rw_o, oe;
    logic [BITW-1:0] bus_drv;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req     (bus.req_valid),
        .ptr     (last_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    always_comb begin
        sel_rw    = RAM_READ;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_gnt[i]) begin
                sel_rw    = bus.req_rw[i];
                sel_addr  = bus.req_addr[i*BITW +: BITW];
                sel_wdata = bus.req_wdata[i*BITW +: BITW];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        rw_d         = rw_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        last_d       = last_q;
        resp_valid_d = '0;
        ready        = '0;
        ram_en       = 1'b0;
        ram_rw_o     = RAM_READ;
        oe           = 1'b0;
        bus_drv      = '0;
        unique case (state_q)
            IDLE: begin
                if (|bus.req_valid) begin
                    ready   = arb_gnt;
                    gnt_d   = arb_gnt;
                    last_d  = arb_idx;
                    rw_d    = sel_rw;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                ram_en   = 1'b1;
                ram_rw_o = rw_q;
                oe       = 1'b1;
                bus_drv  = addr_q;
                state_d  = (rw_q == RAM_WRITE) ? WDATA : RDATA;
            end
            WDATA: begin
                ram_en       = 1'b1;
                ram_rw_o     = RAM_WRITE;
                oe           = 1'b1;
                bus_drv      = wdata_q;
                resp_valid_d = gnt_q;
                state_d      = IDLE;
            end
            RDATA: begin
                ram_en  = 1'b1;
                state_d = RCAP;
            end
            // RAM owns the bus here; sample it on the closing edge.
            RCAP: begin
                rdata_d      = bus.bus_in;
                resp_valid_d = gnt_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            gnt_q        <= '0;
            rw_q         <= RAM_READ;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            last_q       <= IW'(NREQ - 1);
            resp_valid_q <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            rw_q         <= rw_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            last_q       <= last_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    // Ready is combinational from req_valid, so mask it while reset is held.
    assign bus.req_ready  = reset ? '0 : ready;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.ram_enable = ram_en;
    assign bus.ram_rw     = ram_rw_o;
    assign bus.bus_oe     = oe;
    assign bus.bus_out    = bus_drv;
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: queued requester agents, a behavioural bus RAM and a
// transaction-level round-robin/latency model that predicts every accept and response.
module tb_ram_arbiter;
    import cuca_pkg::*;

    localparam int NREQ   = 2;
    localparam int LAT_WR = 3;
    localparam int LAT_RD = 4;

    typedef struct packed {
        logic            rw;
        logic [BITW-1:0] addr;
        logic [BITW-1:0] wdata;
    } op_t;

    typedef struct {
        int              cyc;
        int              r;
        logic [BITW-1:0] data;
        logic            rd;
    } ev_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    ram_arbiter_if #(.NREQ(NREQ)) bif ();
    ram_arbiter #(.NREQ(NREQ)) dut (.clock(clock), .reset(reset), .bus(bif));

    // Behavioural bus RAM: first enabled cycle is the address phase, second the data phase.
    logic [BITW-1:0] ram_mem [256];
    logic [BITW-1:0] ram_a;
    logic            ram_ph, ram_drv;

    initial for (int i = 0; i < 256; i++) ram_mem[i] = '0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            ram_ph  <= 1'b0;
            ram_drv <= 1'b0;
            ram_a   <= '0;
        end else begin
            ram_drv <= 1'b0;
            if (bif.ram_enable) begin
                if (!ram_ph) begin
                    ram_a  <= bif.bus_out;
                    ram_ph <= 1'b1;
                end else begin
                    if (bif.ram_rw == RAM_WRITE) ram_mem[ram_a] <= bif.bus_out;
                    else ram_drv <= 1'b1;
                    ram_ph <= 1'b0;
                end
            end
        end
    end

    assign bif.bus_in = bif.bus_oe ? bif.bus_out : (ram_drv ? ram_mem[ram_a] : '0);

    // Requester agents and bus monitor.
    op_t             opbuf [NREQ][128];
    int              op_n  [NREQ];
    int              op_rd [NREQ];
    ev_t             acc_log[$], rsp_log[$], exp_acc[$], exp_rsp[$];
    int              cyc;
    logic [NREQ-1:0] acc_pend;
    int              guard, cont_viol, cont_cycles;

    initial begin
        cyc = 0; acc_pend = '0; guard = 0; cont_viol = 0; cont_cycles = 0;
        for (int r = 0; r < NREQ; r++) op_rd[r] = 0;
        bif.req_valid = '0; bif.req_rw = '0; bif.req_addr = '0; bif.req_wdata = '0;
        forever begin
            @(posedge clock);
            cyc++;
            #1;
            for (int r = 0; r < NREQ; r++) begin
                if (acc_pend[r]) op_rd[r]++;
                if (op_rd[r] < op_n[r]) begin
                    bif.req_valid[r]               = 1'b1;
                    bif.req_rw[r]                  = opbuf[r][op_rd[r]].rw;
                    bif.req_addr[r*BITW +: BITW]   = opbuf[r][op_rd[r]].addr;
                    bif.req_wdata[r*BITW +: BITW]  = opbuf[r][op_rd[r]].wdata;
                end else begin
                    bif.req_valid[r] = 1'b0;
                end
            end
            acc_pend = '0;
            @(negedge clock);
            if (reset) begin
                guard = 0;
            end else begin
                for (int r = 0; r < NREQ; r++) begin
                    if (bif.req_valid[r] && bif.req_ready[r]) begin
                        acc_log.push_back('{cyc, r, opbuf[r][op_rd[r]].addr, !opbuf[r][op_rd[r]].rw});
                        acc_pend[r] = 1'b1;
                    end
                    if (bif.resp_valid[r]) rsp_log.push_back('{cyc, r, bif.resp_rdata, 1'b0});
                end
                // Three cycles after a read address phase: RDATA, RCAP, IDLE.
                if (guard > 0) begin
                    cont_cycles++;
                    if (bif.bus_oe !== 1'b0) cont_viol++;
                    guard--;
                end
                if (bif.ram_enable && bif.bus_oe && bif.ram_rw == RAM_READ) guard = 3;
            end
        end
    end

    // Reference model state.
    logic [BITW-1:0] ref_mem [256];
    int              mlast;
    int              mstart [NREQ];
    int              acc_base, rsp_base, t0;
    int              n_chk, n_fail;

    function automatic int rr_pick(input logic [NREQ-1:0] pend, input int last);
        for (int k = 1; k <= NREQ; k++)
            if (pend[(last + k) % NREQ]) return (last + k) % NREQ;
        return -1;
    endfunction

    task automatic push_op(input int r, input logic rw, input logic [BITW-1:0] a, input logic [BITW-1:0] d);
        opbuf[r][op_n[r]] = '{rw: rw, addr: a, wdata: d};
        op_n[r]++;
    endtask

    task automatic begin_batch();
        @(posedge clock);
        #2;
        for (int r = 0; r < NREQ; r++) mstart[r] = op_n[r];
        acc_base = acc_log.size();
        rsp_base = rsp_log.size();
        t0 = cyc + 1;
    endtask

    // Transaction-level prediction: every requester with queued ops stays pending,
    // the arbiter serves one op at a time, 3 cycles per write and 4 per read.
    task automatic model_batch();
        int              rd [NREQ];
        int              t, w, lat;
        logic [NREQ-1:0] pend;
        op_t             op;
        exp_acc.delete();
        exp_rsp.delete();
        for (int r = 0; r < NREQ; r++) rd[r] = mstart[r];
        t = t0;
        for (int r = 0; r < NREQ; r++) pend[r] = rd[r] < op_n[r];
        while (pend != '0) begin
            w   = rr_pick(pend, mlast);
            op  = opbuf[w][rd[w]];
            lat = op.rw ? LAT_WR : LAT_RD;
            exp_acc.push_back('{t, w, op.addr, !op.rw});
            exp_rsp.push_back('{t + lat, w, op.rw ? '0 : ref_mem[op.addr], !op.rw});
            if (op.rw) ref_mem[op.addr] = op.wdata;
            mlast = w;
            rd[w]++;
            t += lat;
            for (int r = 0; r < NREQ; r++) pend[r] = rd[r] < op_n[r];
        end
    endtask

    task automatic wait_rsp(input int n, output bit to);
        int k;
        k = 0;
        while (rsp_log.size() < n && k < 400) begin
            @(posedge clock);
            k++;
        end
        #3;
        to = (rsp_log.size() < n);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clock);
        #3;
        n_chk++; if (bif.req_ready !== '0) begin n_fail++; $display("FAIL rst_req_ready got %b want 0", bif.req_ready); end
        n_chk++; if (bif.resp_valid !== '0) begin n_fail++; $display("FAIL rst_resp_valid got %b want 0", bif.resp_valid); end
        n_chk++; if (bif.resp_rdata !== '0) begin n_fail++; $display("FAIL rst_resp_rdata got %h want 0", bif.resp_rdata); end
        n_chk++; if ({bif.ram_enable, bif.ram_rw, bif.bus_oe} !== 3'b000) begin n_fail++; $display("FAIL rst_ram_ctl got %b want 000", {bif.ram_enable, bif.ram_rw, bif.bus_oe}); end
        n_chk++; if (bif.bus_out !== '0) begin n_fail++; $display("FAIL rst_bus_out got %h want 0", bif.bus_out); end
        @(posedge clock);
        #4;
        reset = 1'b0;
        mlast = NREQ - 1;
    endtask

    task automatic test_simultaneous();
        bit to;
        begin_batch();
        push_op(0, RAM_WRITE, 8'h01, 8'h11);
        push_op(1, RAM_WRITE, 8'h02, 8'h22);
        model_batch();
        wait_rsp(rsp_base + 2, to);
        n_chk++; if (to) begin n_fail++; $display("FAIL sim_timeout got %0d responses want 2", rsp_log.size() - rsp_base); end
        n_chk++; if (acc_log[acc_base].r != 0 || acc_log[acc_base].cyc != t0) begin
            n_fail++; $display("FAIL sim_first got req%0d@%0d want req0@%0d", acc_log[acc_base].r, acc_log[acc_base].cyc, t0); end
        n_chk++; if (rsp_log[rsp_base].r != 0 || rsp_log[rsp_base].cyc != t0 + 3) begin
            n_fail++; $display("FAIL sim_resp0 got req%0d@%0d want req0@%0d", rsp_log[rsp_base].r, rsp_log[rsp_base].cyc, t0 + 3); end
        n_chk++; if (acc_log[acc_base+1].r != 1 || acc_log[acc_base+1].cyc != rsp_log[rsp_base].cyc) begin
            n_fail++; $display("FAIL sim_second got req%0d@%0d want req1@%0d", acc_log[acc_base+1].r, acc_log[acc_base+1].cyc, rsp_log[rsp_base].cyc); end
    endtask

    task automatic test_fairness();
        bit to;
        begin_batch();
        for (int i = 0; i < 4; i++) begin
            push_op(0, RAM_WRITE, BITW'(8'h80 + i), BITW'($urandom_range(255, 0)));
            push_op(1, RAM_WRITE, BITW'(8'h90 + i), BITW'($urandom_range(255, 0)));
        end
        model_batch();
        wait_rsp(rsp_base + 8, to);
        n_chk++; if (to) begin n_fail++; $display("FAIL fair_timeout got %0d responses want 8", rsp_log.size() - rsp_base); end
        for (int i = 0; i < 8; i++) begin
            n_chk++;
            if (acc_log[acc_base+i].r != i % 2) begin
                n_fail++; $display("FAIL fair_grant[%0d] got req%0d want req%0d", i, acc_log[acc_base+i].r, i % 2); end
            if (i > 0) begin
                n_chk++;
                if (acc_log[acc_base+i].cyc - acc_log[acc_base+i-1].cyc != 3) begin
                    n_fail++; $display("FAIL fair_gap[%0d] got %0d want 3", i, acc_log[acc_base+i].cyc - acc_log[acc_base+i-1].cyc); end
            end
        end
    endtask

    task automatic test_write_read();
        bit to;
        begin_batch();
        push_op(0, RAM_WRITE, 8'h10, 8'hA5);
        model_batch();
        wait_rsp(rsp_base + 1, to);
        n_chk++; if (to || rsp_log[rsp_base].r != 0 || rsp_log[rsp_base].cyc != acc_log[acc_base].cyc + 3) begin
            n_fail++; $display("FAIL wr_resp got req%0d@%0d want req0@%0d", rsp_log[rsp_base].r, rsp_log[rsp_base].cyc, acc_log[acc_base].cyc + 3); end
        n_chk++; if (ram_mem[8'h10] !== 8'hA5) begin n_fail++; $display("FAIL wr_ram got %h want a5", ram_mem[8'h10]); end
        begin_batch();
        push_op(0, RAM_READ, 8'h10, 8'h00);
        model_batch();
        wait_rsp(rsp_base + 1, to);
        n_chk++; if (to || rsp_log[rsp_base].r != 0 || rsp_log[rsp_base].cyc != acc_log[acc_base].cyc + 4) begin
            n_fail++; $display("FAIL rd_resp got req%0d@%0d want req0@%0d", rsp_log[rsp_base].r, rsp_log[rsp_base].cyc, acc_log[acc_base].cyc + 4); end
        n_chk++; if (rsp_log[rsp_base].data !== 8'hA5) begin n_fail++; $display("FAIL rd_data got %h want a5", rsp_log[rsp_base].data); end
        begin_batch();
        push_op(1, RAM_WRITE, 8'h20, 8'h3C);
        model_batch();
        wait_rsp(rsp_base + 1, to);
        n_chk++; if (to || bif.resp_rdata !== 8'hA5) begin n_fail++; $display("FAIL rdata_hold got %h want a5", bif.resp_rdata); end
    endtask

    task automatic test_reset_mid_read();
        bit to;
        int k, c;
        begin_batch();
        push_op(0, RAM_READ, 8'h20, 8'h00);
        k = 0;
        while (acc_log.size() <= acc_base && k < 20) begin @(negedge clock); k++; end
        n_chk++; if (acc_log.size() <= acc_base) begin n_fail++; $display("FAIL rmr_accept got none want req0"); end
        c = acc_log[acc_base].cyc;
        while (cyc < c + 2) begin @(posedge clock); #3; end
        n_chk++; if ({bif.ram_enable, bif.ram_rw, bif.bus_oe} !== 3'b100) begin
            n_fail++; $display("FAIL rmr_rdata_phase got %b want 100", {bif.ram_enable, bif.ram_rw, bif.bus_oe}); end
        reset = 1'b1;
        #1;
        n_chk++; if ({bif.ram_enable, bif.bus_oe} !== 2'b00) begin
            n_fail++; $display("FAIL rmr_async got en=%b oe=%b want 0 0", bif.ram_enable, bif.bus_oe); end
        n_chk++; if (bif.resp_valid !== '0) begin n_fail++; $display("FAIL rmr_resp_in_reset got %b want 0", bif.resp_valid); end
        repeat (2) @(posedge clock);
        #4;
        reset = 1'b0;
        mlast = NREQ - 1;
        repeat (6) @(posedge clock);
        #3;
        n_chk++; if (rsp_log.size() != rsp_base) begin
            n_fail++; $display("FAIL rmr_dropped got %0d responses want 0", rsp_log.size() - rsp_base); end
        begin_batch();
        push_op(0, RAM_READ, 8'h10, 8'h00);
        push_op(1, RAM_READ, 8'h20, 8'h00);
        model_batch();
        wait_rsp(rsp_base + 2, to);
        n_chk++; if (to) begin n_fail++; $display("FAIL rmr_fresh_timeout got %0d responses want 2", rsp_log.size() - rsp_base); end
        for (int i = 0; i < 2; i++) begin
            n_chk++;
            if (acc_log[acc_base+i].r != exp_acc[i].r || acc_log[acc_base+i].cyc != exp_acc[i].cyc ||
                rsp_log[rsp_base+i].cyc != exp_rsp[i].cyc || rsp_log[rsp_base+i].data !== exp_rsp[i].data) begin
                n_fail++; $display("FAIL rmr_fresh[%0d] got req%0d acc@%0d rsp@%0d data %h want req%0d acc@%0d rsp@%0d data %h", i,
                    acc_log[acc_base+i].r, acc_log[acc_base+i].cyc, rsp_log[rsp_base+i].cyc, rsp_log[rsp_base+i].data,
                    exp_acc[i].r, exp_acc[i].cyc, exp_rsp[i].cyc, exp_rsp[i].data);
            end
        end
    endtask

    task automatic test_idle();
        int bad;
        bad = 0;
        acc_base = acc_log.size();
        repeat (20) begin
            @(negedge clock);
            if (bif.ram_enable !== 1'b0 || bif.req_ready !== '0) bad++;
        end
        n_chk++; if (bad != 0) begin n_fail++; $display("FAIL idle_quiet got %0d busy cycles want 0", bad); end
        n_chk++; if (acc_log.size() != acc_base) begin n_fail++; $display("FAIL idle_accept got %0d want 0", acc_log.size() - acc_base); end
    endtask

    task automatic test_random();
        bit to;
        begin_batch();
        for (int i = 0; i < 10; i++)
            for (int r = 0; r < NREQ; r++)
                push_op(r, 1'($urandom_range(1, 0)), BITW'(8'h40 + $urandom_range(7, 0)), BITW'($urandom_range(255, 0)));
        model_batch();
        wait_rsp(rsp_base + exp_rsp.size(), to);
        n_chk++; if (to) begin n_fail++; $display("FAIL rand_timeout got %0d responses want %0d", rsp_log.size() - rsp_base, exp_rsp.size()); end
        for (int i = 0; i < exp_acc.size(); i++) begin
            n_chk++;
            if (acc_log[acc_base+i].r != exp_acc[i].r || acc_log[acc_base+i].cyc != exp_acc[i].cyc) begin
                n_fail++; $display("FAIL rand_acc[%0d] got req%0d@%0d want req%0d@%0d", i,
                    acc_log[acc_base+i].r, acc_log[acc_base+i].cyc, exp_acc[i].r, exp_acc[i].cyc);
            end
            n_chk++;
            if (rsp_log[rsp_base+i].r != exp_rsp[i].r || rsp_log[rsp_base+i].cyc != exp_rsp[i].cyc ||
                (exp_rsp[i].rd && rsp_log[rsp_base+i].data !== exp_rsp[i].data)) begin
                n_fail++; $display("FAIL rand_rsp[%0d] got req%0d@%0d data %h want req%0d@%0d data %h", i,
                    rsp_log[rsp_base+i].r, rsp_log[rsp_base+i].cyc, rsp_log[rsp_base+i].data,
                    exp_rsp[i].r, exp_rsp[i].cyc, exp_rsp[i].data);
            end
        end
    endtask

    task automatic test_contention();
        n_chk++; if (cont_viol != 0) begin n_fail++; $display("FAIL contention got %0d bus_oe cycles want 0", cont_viol); end
        n_chk++; if (cont_cycles == 0) begin n_fail++; $display("FAIL contention_cover got 0 guarded cycles want >0"); end
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        mlast = NREQ - 1;
        for (int r = 0; r < NREQ; r++) op_n[r] = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        test_reset();
        test_simultaneous();
        test_fairness();
        test_write_read();
        test_reset_mid_read();
        test_idle();
        test_random();
        test_contention();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Sequencer and round-robin arbiter that shares the single-port bus RAM between `NREQ` requesters (CPU fetch, CPU data, DMA). Each requester issues a read or write with a valid/ready handshake. The block runs the RAM's two-phase bus protocol: an address phase, then a data phase, with one extra capture cycle for reads. It returns write acknowledgements and read data on per-requester response pulses. It sits between the requesters and the RAM, and the top level builds the tri-state bus from `bus_out`/`bus_oe`.

## Interface
- `NREQ`, default 2: number of requesters, legal 2..4.
- `BITW`, default 8: address and data width, taken from the package.

Ports:
- `clock`  in  1  system clock; everything is rising-edge.
- `reset`  in  1  asynchronous, active-high.
- `req_valid`  in  NREQ  request pending, one bit per requester.
- `req_rw`  in  NREQ  0 = read, 1 = write.
- `req_addr`  in  NREQ*BITW  packed addresses; slice i belongs to requester i.
- `req_wdata`  in  NREQ*BITW  packed write data.
- `req_ready`  out  NREQ  one-hot; the request is accepted in the cycle where `valid & ready`.
- `resp_valid`  out  NREQ  one-hot single-cycle completion pulse.
- `resp_rdata`  out  BITW  read data; valid only with a read response.
- `ram_enable`  out  1  RAM enable.
- `ram_rw`  out  1  RAM rw.
- `bus_out`  out  BITW  value driven onto the shared bus.
- `bus_oe`  out  1  bus drive enable.
- `bus_in`  in  BITW  current value of the shared bus.

## Operation
- States: IDLE, ADDR, WDATA, RDATA, RCAP.
- IDLE:
  - If any `req_valid` is set, the round-robin picks grant g and `req_ready[g]=1` combinationally.
  - On that edge the block latches g, rw, addr and wdata, and goes to ADDR.
  - With no valid request it stays in IDLE.
- ADDR: `ram_enable=1`, `ram_rw`=latched rw, `bus_oe=1`, `bus_out`=addr. Goes to WDATA if rw=1, else RDATA.
- WDATA: `ram_enable=1`, `ram_rw=1`, `bus_oe=1`, `bus_out`=wdata. Goes to IDLE and registers `resp_valid[g]`.
- RDATA: `ram_enable=1`, `ram_rw=0`, `bus_oe=0`. Goes to RCAP.
- RCAP:
  - `ram_enable=0`, `bus_oe=0`; the RAM drives the bus.
  - `bus_in` is captured into `resp_rdata` at the closing edge.
  - Goes to IDLE and registers `resp_valid[g]`.
- Round-robin:
  - Pointer `last` holds the previous grant.
  - Priority search starts at `last+1` modulo NREQ.
  - `last` updates only on acceptance.
  - Reset sets `last=NREQ-1`, so requester 0 wins first.
- Requester obligations: `req_valid`, `req_rw`, `req_addr` and `req_wdata` hold stable until accepted. A non-granted requester keeps waiting; nothing is dropped.
- `bus_oe` is never 1 in RDATA, RCAP, or the IDLE cycle that follows RCAP. This is the bus-contention rule.
- `resp_rdata` holds its last captured value between reads.

## Timing
- Reset value of every output is 0, and the state is IDLE.
- Reset mid-transaction:
  - Asynchronous return to IDLE, with all outputs 0 immediately.
  - The in-flight request is dropped and no response is issued.
  - `last` returns to NREQ-1.
- Write accepted at cycle T:
  - ADDR at T+1, WDATA at T+2.
  - `resp_valid` at T+3.
  - The next acceptance can happen at T+3 (3 cycles per write).
- Read accepted at cycle T:
  - ADDR at T+1, RDATA at T+2, RCAP at T+3.
  - `resp_valid` with `resp_rdata` at T+4.
  - The next acceptance can happen at T+4 (4 cycles per read).
- `resp_valid` of the previous transaction and `req_ready` of the next one may assert in the same cycle.
- A requester may raise a new `req_valid` in the same cycle it receives `resp_valid`.

## Structure
- Shared package `cuca_pkg` holds:
  - `BITW`;
  - `arb_state_t` enum (IDLE, ADDR, WDATA, RDATA, RCAP);
  - the `RAM_READ`/`RAM_WRITE` rw constants.
- One sub-module, `rr_arbiter`:
  - parameter NREQ;
  - inputs: request vector, pointer;
  - output: one-hot grant plus index;
  - purely combinational.
- The FSM, latches and pointer live in `ram_arbiter`.

## Test plan
- Write then read:
  - Req0 writes 0xA5 to 0x10 (accepted at T): `resp_valid[0]` at T+3; RAM[0x10]=0xA5.
  - Req0 then reads 0x10 (accepted at T'): `resp_valid[0]` with `resp_rdata`=0xA5 at T'+4.
- Simultaneous start: both `req_valid` raised together after reset → req0 is granted first; req1 is accepted in the cycle req0's `resp_valid` fires.
- Fairness: both requesters hold `req_valid` continuously with writes → grants alternate 0,1,0,1 over 8 transactions, with exactly 3 cycles between acceptances.
- Reset mid-read:
  - Stimulus: `reset` asserted during RDATA.
  - Required: `ram_enable` and `bus_oe` go to 0 asynchronously and no `resp_valid` is issued.
  - After release, a fresh request is served normally.
- Idle and contention checks:
  - With no `req_valid` for 20 cycles, `ram_enable` stays 0.
  - An assertion checks `bus_oe` is 0 in every RDATA, RCAP and following IDLE cycle throughout all tests.
